psum_buffer: RTL and testbench

Circular partial-sum buffer for the CNN accelerator datapath. Each valid cycle it adds the four PE outputs to the oldest stored partial sum and recirculates the result to the tail. This accumulates a row of `depth` output pixels across filter rows and channels. Dedicated commands seed the buffer with zeros and drain finished sums downstream while re-zeroing them for the next filter.

---
 rtl/psum_pkg.sv | 32 +++
 rtl/psum_add5.sv | 18 +
 rtl/psum_buffer.sv | 76 +++++++
 tb/tb_psum_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared defaults and command decode
// for the circular partial-sum buffer.
package psum_pkg;

  localparam int DATA_WIDTH = 25;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 8;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_INIT,
    CMD_DRAIN,
    CMD_ACC
  } cmd_e;

  // init beats drain beats accumulate
  function automatic cmd_e cmd_decode(
    input logic init,
    input logic wz,
    input logic vd
  );
    cmd_e c;
    priority case (1'b1)
      init:    c = CMD_INIT;
      wz:      c = CMD_DRAIN;
      vd:      c = CMD_ACC;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/psum_add5.sv
// psum_add5: head plus four PE products,
// wrapping modulo 2**data_width.
module psum_add5 #(
  parameter int data_width = 25
) (
  input  logic signed [data_width-1:0] head_i,
  input  logic signed [data_width-1:0] pe0_i,
  input  logic signed [data_width-1:0] pe1_i,
  input  logic signed [data_width-1:0] pe2_i,
  input  logic signed [data_width-1:0] pe3_i,
  output logic signed [data_width-1:0] sum_o
);

  // Same-width add gives two's-complement wrap.
  assign sum_o = head_i + pe0_i + pe1_i
               + pe2_i + pe3_i;

endmodule

// File: rtl/psum_buffer.sv
// psum_buffer: always-full circular buffer of
// partial sums with init / drain / accumulate.
module psum_buffer
  import psum_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int depth      = DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         p_valid_data,
  input  logic                         p_write_zero,
  input  logic                         p_init,
  input  logic signed [data_width-1:0] pe0_data,
  input  logic signed [data_width-1:0] pe1_data,
  input  logic signed [data_width-1:0] pe2_data,
  input  logic signed [data_width-1:0] pe3_data,
  output logic signed [data_width-1:0] fifo_out,
  output logic                         valid_fifo_out
);

  logic signed [data_width-1:0] mem_q [depth];
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic signed [data_width-1:0] head;
  logic signed [data_width-1:0] sum;
  logic signed [data_width-1:0] head_d;
  cmd_e cmd;

  assign cmd  = cmd_decode(p_init, p_write_zero,
                           p_valid_data);
  assign head = mem_q[ptr_q];

  psum_add5 #(
    .data_width(data_width)
  ) u_add5 (
    .head_i(head),
    .pe0_i (pe0_data),
    .pe1_i (pe1_data),
    .pe2_i (pe2_data),
    .pe3_i (pe3_data),
    .sum_o (sum)
  );

  always_comb begin
    head_d = head;
    ptr_d  = ptr_q;
    unique case (cmd)
      CMD_INIT, CMD_DRAIN: begin
        head_d = '0;
        ptr_d  = ptr_q + 1'b1;
      end
      CMD_ACC: begin
        head_d = sum;
        ptr_d  = ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Rewriting the head and stepping moves it to the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < depth; i++)
        mem_q[i] <= '0;
    end else if (cmd != CMD_NONE) begin
      mem_q[ptr_q] <= head_d;
      ptr_q        <= ptr_d;
    end
  end

  assign fifo_out       = head;
  assign valid_fifo_out = p_write_zero & ~p_init & ~rst;

endmodule

// File: tb/tb_psum_buffer.sv
// tb_psum_buffer: directed steps with a reference
// model and a drain scoreboard queue.
module tb_psum_buffer;

  localparam int W = 25;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  logic p_valid_data, p_write_zero, p_init;
  logic signed [W-1:0] pe0, pe1, pe2, pe3;
  logic signed [W-1:0] fifo_out;
  logic valid_fifo_out;

  int compared = 0;
  int mismatched = 0;

  logic signed [W-1:0] m [D];
  int mptr;
  logic signed [W-1:0] sb_q [$];
  logic signed [W-1:0] exp_v;

  always #5 clk = ~clk;

  psum_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .p_valid_data  (p_valid_data),
    .p_write_zero  (p_write_zero),
    .p_init        (p_init),
    .pe0_data      (pe0),
    .pe1_data      (pe1),
    .pe2_data      (pe2),
    .pe3_data      (pe3),
    .fifo_out      (fifo_out),
    .valid_fifo_out(valid_fifo_out)
  );

  task automatic chk_v(input string tag,
                       input logic signed [W-1:0] obs,
                       input logic signed [W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  task automatic chk_b(input string tag,
                       input logic obs,
                       input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, expv);
    end
  endtask

  // One cycle: drive, sample mid-cycle, clock, update model.
  task automatic step(input logic init, input logic wz,
                      input logic vd,
                      input logic signed [W-1:0] a,
                      input logic signed [W-1:0] b,
                      input logic signed [W-1:0] c,
                      input logic signed [W-1:0] d,
                      input logic signed [W-1:0] drain_exp);
    logic signed [W-1:0] popped;
    p_init = init; p_write_zero = wz; p_valid_data = vd;
    pe0 = a; pe1 = b; pe2 = c; pe3 = d;
    if (wz && !init) sb_q.push_back(drain_exp);
    #4;
    chk_b("valid", valid_fifo_out, wz && !init);
    chk_v("head", fifo_out, m[mptr]);
    if (valid_fifo_out) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL drain_sb: observed %0d expected none",
               fifo_out);
      end else begin
        popped = sb_q.pop_front();
        chk_v("drain_sb", fifo_out, popped);
      end
    end
    @(posedge clk); #1;
    if (init || wz) begin
      m[mptr] = '0;
      mptr = (mptr + 1) % D;
    end else if (vd) begin
      m[mptr] = m[mptr] + a + b + c + d;
      mptr = (mptr + 1) % D;
    end
    p_init = 0; p_write_zero = 0; p_valid_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < D; i++) m[i] = '0;
    mptr = 0;
  endtask

  initial begin
    rst = 1'b0;
    p_valid_data = 0; p_write_zero = 0; p_init = 0;
    pe0 = '0; pe1 = '0; pe2 = '0; pe3 = '0;
    for (int i = 0; i < D; i++) m[i] = 'x;
    mptr = 0;
    @(posedge clk); #1;

    // Reset
    rst = 1'b1;
    p_write_zero = 1'b1;
    #1;
    chk_b("rst_valid", valid_fifo_out, 1'b0);
    p_write_zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < D; i++) m[i] = '0;
    mptr = 0;
    chk_v("rst_fifo", fifo_out, 0);
    chk_b("rst_valid2", valid_fifo_out, 1'b0);

    // Init pass
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0);

    // Accumulate pass 1
    step(0, 0, 1, 1, 1, 1, 2, 0);
    for (int k = 2; k <= 8; k++)
      step(0, 0, 1, 1, W'(k), 2, 2, 0);
    #1 chk_v("pass1_head", fifo_out, 25'sd5);

    // Accumulate pass 2
    step(0, 0, 1, 1, 1, 2, 2, 0);
    for (int k = 2; k <= 8; k++)
      step(0, 0, 1, 1, W'(k), 2, 2, 0);

    // Drain with test-plan constants
    for (int k = 0; k < D; k++) begin
      case (k)
        0: exp_v = 11;
        default: exp_v = W'(10 + 2 * k + 2);
      endcase
      step(0, 1, 0, 0, 0, 0, 0, exp_v);
    end
    for (int k = 0; k < D; k++)
      step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_v("post_drain", fifo_out, 0);

    // Priority: init over accumulate
    step(1, 0, 1, 5, 5, 5, 5, 0);
    // Priority: drain over accumulate
    step(0, 1, 1, 7, 7, 7, 7, 0);
    // Wrap: 0xFFFFFF + 1 in slot 2
    step(0, 0, 1, 25'sh0FFFFFF, 0, 0, 0, 0);
    for (int k = 0; k < D - 1; k++)
      step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_v("wrap_pre", fifo_out, 25'sh0FFFFFF);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < D - 1; k++)
      step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, -25'sd16777216);

    // Hold with no command
    step(0, 0, 1, 3, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-pass reset discards sums
    for (int k = 0; k < D - 1; k++)
      step(0, 0, 1, 9, 9, 9, 9, 0);
    do_reset();
    chk_v("midrst_fifo", fifo_out, 0);
    for (int k = 0; k < D; k++)
      step(0, 1, 0, 0, 0, 0, 0, 0);

    compared++;
    assert (sb_q.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_empty: observed %0d expected 0",
             sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
